// File: rtl/stack_alu_sequencer.sv
// stack_alu_sequencer: postfix token front-end that drives a push/add/mul/pop stack ALU.
// Optional macro SEQ_OVF_ABORT_EN: an ALU overflow aborts the expression like a malformed token.
module stack_alu_sequencer #(
  parameter int N     = 4,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tok_valid,
  output logic         tok_ready,
  input  logic [1:0]   tok_kind,
  input  logic [N-1:0] tok_data,
  output logic [2:0]   alu_opcode,
  output logic [N-1:0] alu_in,
  input  logic [N-1:0] alu_out,
  input  logic         alu_overflow,
  output logic         res_valid,
  output logic [N-1:0] res_data,
  output logic         res_overflow,
  output logic         res_error
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] DEPTH_FULL = DW'(DEPTH);
  localparam logic [DW-1:0] DEPTH_TWO  = DW'(2);
  localparam logic [DW-1:0] DEPTH_ONE  = DW'(1);

  localparam logic [1:0] KIND_OPERAND = 2'b00;
  localparam logic [1:0] KIND_ADD     = 2'b01;
  localparam logic [1:0] KIND_MUL     = 2'b10;
  localparam logic [1:0] KIND_END     = 2'b11;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  typedef enum logic [2:0] {ACCEPT, ISSUE, CHECK, CAPTURE, DRAIN, FLUSH} state_t;

  state_t        state_reg, state_next;
  logic [2:0]    opcode_reg, opcode_next;
  logic [N-1:0]  operand_reg, operand_next;
  logic [DW-1:0] depth_reg, depth_next;
  logic          ovf_reg, ovf_next;
  logic          flush_reg, flush_next;
  logic          res_valid_reg, res_valid_next;
  logic [N-1:0]  res_data_reg, res_data_next;
  logic          res_overflow_reg, res_overflow_next;
  logic          res_error_reg, res_error_next;
  logic          transfer;
  logic          raise_error;
  logic          error_flush;
  logic          abort_ovf;

  assign tok_ready    = !rst && (state_reg == ACCEPT || state_reg == FLUSH);
  assign transfer     = tok_valid && tok_ready;
  assign alu_opcode   = opcode_reg;
  assign alu_in       = operand_reg;
  assign res_valid    = res_valid_reg;
  assign res_data     = res_data_reg;
  assign res_overflow = res_overflow_reg;
  assign res_error    = res_error_reg;

  always_comb begin
    state_next        = state_reg;
    opcode_next       = opcode_reg;
    operand_next      = operand_reg;
    depth_next        = depth_reg;
    ovf_next          = ovf_reg;
    flush_next        = flush_reg;
    res_valid_next    = 1'b0;
    res_data_next     = res_data_reg;
    res_overflow_next = res_overflow_reg;
    res_error_next    = res_error_reg;
    raise_error       = 1'b0;
    error_flush       = 1'b0;
    abort_ovf         = 1'b0;

    case (state_reg)
      ACCEPT: begin
        if (transfer) begin
          error_flush = (tok_kind != KIND_END);
          case (tok_kind)
            KIND_OPERAND: begin
              if (depth_reg < DEPTH_FULL) begin
                opcode_next  = OP_PUSH;
                operand_next = tok_data;
                depth_next   = depth_reg + DEPTH_ONE;
                state_next   = ISSUE;
              end else begin
                raise_error = 1'b1;
              end
            end
            KIND_ADD, KIND_MUL: begin
              if (depth_reg >= DEPTH_TWO) begin
                opcode_next = (tok_kind == KIND_ADD) ? OP_ADD : OP_MUL;
                depth_next  = depth_reg - DEPTH_ONE;
                state_next  = ISSUE;
              end else begin
                raise_error = 1'b1;
              end
            end
            default: begin
              if (depth_reg == DEPTH_ONE) begin
                opcode_next = OP_POP;
                depth_next  = '0;
                state_next  = ISSUE;
              end else begin
                raise_error = 1'b1;
              end
            end
          endcase
        end
      end
      ISSUE: begin
        opcode_next = OP_NOP;
        if (opcode_reg == OP_ADD || opcode_reg == OP_MUL) begin
          state_next = CHECK;
        end else if (opcode_reg == OP_POP) begin
          state_next = CAPTURE;
        end else begin
          state_next = ACCEPT;
        end
      end
      CHECK: begin
        ovf_next   = ovf_reg | alu_overflow;
        state_next = ACCEPT;
`ifdef SEQ_OVF_ABORT_EN
        if (alu_overflow) begin
          raise_error = 1'b1;
          error_flush = 1'b1;
          abort_ovf   = 1'b1;
        end
`endif
      end
      CAPTURE: begin
        res_valid_next    = 1'b1;
        res_data_next     = alu_out;
        res_overflow_next = ovf_reg;
        res_error_next    = 1'b0;
        ovf_next          = 1'b0;
        state_next        = ACCEPT;
      end
      DRAIN: begin
        // Pops alternate with nop cycles; leave only after the trailing nop.
        if (opcode_reg == OP_POP) begin
          opcode_next = OP_NOP;
        end else if (depth_reg != '0) begin
          opcode_next = OP_POP;
          depth_next  = depth_reg - DEPTH_ONE;
        end else begin
          state_next = flush_reg ? FLUSH : ACCEPT;
        end
      end
      FLUSH: begin
        if (transfer && tok_kind == KIND_END) begin
          state_next = ACCEPT;
        end
      end
      default: state_next = ACCEPT;
    endcase

    if (raise_error) begin
      res_valid_next    = 1'b1;
      res_error_next    = 1'b1;
      res_data_next     = '0;
      res_overflow_next = ovf_reg | abort_ovf;
      ovf_next          = 1'b0;
      flush_next        = error_flush;
      if (depth_reg != '0) begin
        opcode_next = OP_POP;
        depth_next  = depth_reg - DEPTH_ONE;
        state_next  = DRAIN;
      end else begin
        state_next = error_flush ? FLUSH : ACCEPT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ACCEPT;
      opcode_reg       <= OP_NOP;
      operand_reg      <= '0;
      depth_reg        <= '0;
      ovf_reg          <= 1'b0;
      flush_reg        <= 1'b0;
      res_valid_reg    <= 1'b0;
      res_data_reg     <= '0;
      res_overflow_reg <= 1'b0;
      res_error_reg    <= 1'b0;
    end else begin
      state_reg        <= state_next;
      opcode_reg       <= opcode_next;
      operand_reg      <= operand_next;
      depth_reg        <= depth_next;
      ovf_reg          <= ovf_next;
      flush_reg        <= flush_next;
      res_valid_reg    <= res_valid_next;
      res_data_reg     <= res_data_next;
      res_overflow_reg <= res_overflow_next;
      res_error_reg    <= res_error_next;
    end
  end
endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Bench for stack_alu_sequencer: behavioural stack ALU plus an expression-level reference evaluator.
module tb_stack_alu_sequencer;
  localparam int N = 4;
  localparam int DEPTH = 8;
  localparam int SMIN = -(1 << (N - 1));
  localparam int SMAX = (1 << (N - 1)) - 1;
  localparam logic [1:0] K_OP = 2'b00, K_ADD = 2'b01, K_MUL = 2'b10, K_END = 2'b11;

  logic         clk = 1'b0;
  logic         rst;
  logic         tok_valid;
  logic         tok_ready;
  logic [1:0]   tok_kind;
  logic [N-1:0] tok_data;
  logic [2:0]   alu_opcode;
  logic [N-1:0] alu_in;
  logic [N-1:0] alu_out;
  logic         alu_overflow;
  logic         res_valid;
  logic [N-1:0] res_data;
  logic         res_overflow;
  logic         res_error;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  stack_alu_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_kind(tok_kind), .tok_data(tok_data),
    .alu_opcode(alu_opcode), .alu_in(alu_in), .alu_out(alu_out), .alu_overflow(alu_overflow),
    .res_valid(res_valid), .res_data(res_data), .res_overflow(res_overflow), .res_error(res_error)
  );

  function automatic int sx(input logic [N-1:0] v);
    return int'($signed(v));
  endfunction

  // Behavioural stack ALU responding to the sequencer's opcodes.
  logic [N-1:0] alu_stack[$];
  int alu_a, alu_b, alu_r;
  always @(posedge clk) begin
    if (rst) begin
      alu_stack.delete();
      alu_out      <= '0;
      alu_overflow <= 1'b0;
    end else begin
      case (alu_opcode)
        3'b110: alu_stack.push_back(alu_in);
        3'b100, 3'b101: begin
          if (alu_stack.size() >= 2) begin
            alu_b = sx(alu_stack.pop_back());
            alu_a = sx(alu_stack.pop_back());
            alu_r = (alu_opcode == 3'b100) ? alu_a + alu_b : alu_a * alu_b;
            alu_overflow <= (alu_r < SMIN) || (alu_r > SMAX);
            alu_stack.push_back(N'(alu_r));
          end
        end
        3'b111: if (alu_stack.size() > 0) alu_out <= alu_stack.pop_back();
        default: ;
      endcase
    end
  end

  // Monitors: pop count, non-nop opcode log, result pulses.
  int pop_cnt = 0;
  logic [2:0]   op_log[$];
  logic [N+1:0] res_q[$];
  always @(negedge clk) begin
    if (alu_opcode == 3'b111) pop_cnt++;
    if (alu_opcode != 3'b000) op_log.push_back(alu_opcode);
    if (res_valid) res_q.push_back({res_error, res_overflow, res_data});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference evaluator working on whole-expression values.
  int m_stack[$];
  bit m_flush = 1'b0;
  bit m_ovf = 1'b0;
  logic [N+1:0] last_res;

  task automatic model_step(input logic [1:0] kind, input logic [N-1:0] data,
                            output bit has_res, output logic [N+1:0] exp_res,
                            output int exp_pops, output int exp_wait, output bit exp_err_now);
    int a, b, r;
    bit o;
    has_res = 1'b0; exp_res = '0; exp_pops = 0; exp_wait = 1; exp_err_now = 1'b0;
    if (m_flush) begin
      if (kind == K_END) m_flush = 1'b0;
      return;
    end
    case (kind)
      K_OP: begin
        if (m_stack.size() < DEPTH) begin
          m_stack.push_back(sx(data));
          exp_wait = 2;
          return;
        end
      end
      K_ADD, K_MUL: begin
        if (m_stack.size() >= 2) begin
          b = m_stack.pop_back();
          a = m_stack.pop_back();
          r = (kind == K_ADD) ? a + b : a * b;
          o = (r < SMIN) || (r > SMAX);
          m_stack.push_back(sx(N'(r)));
`ifdef SEQ_OVF_ABORT_EN
          if (o) begin
            has_res = 1'b1;
            exp_res = {1'b1, 1'b1, {N{1'b0}}};
            exp_pops = m_stack.size();
            exp_wait = 3 + 2 * exp_pops;
            m_stack.delete();
            m_ovf = 1'b0;
            m_flush = 1'b1;
            return;
          end
`endif
          m_ovf = m_ovf | o;
          exp_wait = 3;
          return;
        end
      end
      default: begin
        if (m_stack.size() == 1) begin
          has_res = 1'b1;
          exp_res = {1'b0, m_ovf, N'(m_stack.pop_back())};
          exp_pops = 1;
          exp_wait = 3;
          m_ovf = 1'b0;
          return;
        end
      end
    endcase
    has_res = 1'b1;
    exp_res = {1'b1, m_ovf, {N{1'b0}}};
    exp_pops = m_stack.size();
    exp_wait = 1 + 2 * exp_pops;
    exp_err_now = 1'b1;
    m_stack.delete();
    m_ovf = 1'b0;
    m_flush = (kind != K_END);
  endtask

  task automatic send_tok(input logic [1:0] kind, input logic [N-1:0] data);
    int guard, waited, pops0, exp_pops, exp_wait;
    bit has_res, exp_err_now, rv_first;
    logic [N+1:0] exp_res, got;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    tok_kind = kind;
    tok_data = data;
    tok_valid = 1'b1;
    guard = 0;
    while (!tok_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!tok_ready) begin
      check("accept_timeout", 32'(tok_ready), 32'd1);
      tok_valid = 1'b0;
      return;
    end
    pops0 = pop_cnt;
    model_step(kind, data, has_res, exp_res, exp_pops, exp_wait, exp_err_now);
    @(posedge clk);
    #1;
    tok_valid = 1'b0;
    tok_kind = 2'($urandom);
    tok_data = N'($urandom);
    @(negedge clk);
    rv_first = res_valid;
    waited = 1;
    while (!tok_ready && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    #1;
    check("ready_latency", waited, exp_wait);
    check("pop_count", pop_cnt - pops0, exp_pops);
    check("err_next_cycle", 32'(rv_first), 32'(exp_err_now));
    check("res_count", res_q.size(), 32'(has_res));
    if (has_res && res_q.size() > 0) begin
      got = res_q.pop_front();
      check("result", 32'(got), 32'(exp_res));
      last_res = got;
    end
    res_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(tok_ready), 32'd0);
    check({tag, "_opcode"}, 32'(alu_opcode), 32'd0);
    check({tag, "_alu_in"}, 32'(alu_in), 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_data"}, 32'(res_data), 32'd0);
    check({tag, "_res_ovf"}, 32'(res_overflow), 32'd0);
    check({tag, "_res_err"}, 32'(res_error), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] exp_ops[4];
    int r;
    exp_ops = '{3'b110, 3'b110, 3'b100, 3'b111};
    rst = 1'b1; tok_valid = 1'b0; tok_kind = K_OP; tok_data = '0; last_res = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    #1;
    check("ready_after_reset", 32'(tok_ready), 32'd1);

    op_log.delete();
    send_tok(K_OP, 4'd3); send_tok(K_OP, 4'd5); send_tok(K_ADD, 4'd0); send_tok(K_END, 4'd0);
    check("op_seq_len", op_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < op_log.size(); i++) check("op_seq", 32'(op_log[i]), 32'(exp_ops[i]));
    check("sum_3_5", 32'(last_res[N-1:0]), 32'd8);

    send_tok(K_OP, 4'd7); send_tok(K_OP, 4'd1); send_tok(K_ADD, 4'd0); send_tok(K_END, 4'd0);
    check("ovf_7_1", 32'(last_res[N]), 32'd1);

    send_tok(K_OP, 4'd2); send_tok(K_ADD, 4'd0);
    check("short_add_err", 32'(last_res[N+1]), 32'd1);
    send_tok(K_OP, 4'd5); send_tok(K_END, 4'd0);
    send_tok(K_OP, 4'd4); send_tok(K_END, 4'd0);
    check("after_flush", 32'(last_res), 32'd4);

    for (int i = 0; i < 9; i++) send_tok(K_OP, N'(i));
    send_tok(K_END, 4'd0);

    send_tok(K_OP, 4'd1); send_tok(K_OP, 4'd2); send_tok(K_END, 4'd0);
    send_tok(K_OP, 4'd6); send_tok(K_OP, 4'd3); send_tok(K_MUL, 4'd0); send_tok(K_END, 4'd0);
    check("mul_ovf_flag", 32'(last_res[N]), 32'd1);

    // In-flight reset with a toggling token valid.
    send_tok(K_OP, 4'd1); send_tok(K_OP, 4'd2);
    tok_kind = K_ADD; tok_valid = 1'b1; rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      tok_valid = 1'($urandom_range(0, 1));
    end
    #1;
    check_reset_outputs("midreset");
    tok_valid = 1'b0; rst = 1'b0;
    m_stack.delete(); m_flush = 1'b0; m_ovf = 1'b0; res_q.delete();
    #1;
    check("ready_after_midreset", 32'(tok_ready), 32'd1);
    send_tok(K_OP, 4'd1); send_tok(K_OP, 4'd1); send_tok(K_ADD, 4'd0); send_tok(K_END, 4'd0);
    check("sum_after_reset", 32'(last_res), 32'd2);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 50) send_tok(K_OP, N'($urandom));
      else if (r < 65) send_tok(K_ADD, 4'd0);
      else if (r < 80) send_tok(K_MUL, 4'd0);
      else send_tok(K_END, 4'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/stack_alu_sequencer.md
# stack_alu_sequencer

Front-end driver for the stack-based ALU, sitting at the opposite end of its opcode/operand port. It accepts a postfix token stream over a valid/ready handshake and issues the matching push/add/mul/pop commands to the ALU. It tracks stack depth, collects the popped result together with overflow status, and reports malformed expressions. After an error it drains the ALU stack so the next expression starts clean.

## Interface
- `N`, 4: data width; must equal the ALU's `n`.
- `DEPTH`, 8: ALU stack capacity in entries.

- `clk`  in  1  rising-edge clock shared with the ALU.
- `rst`  in  1  synchronous, active-high reset.
- `tok_valid`  in  1  a token is present.
- `tok_ready`  out  1  sequencer accepts the token this cycle.
- `tok_kind`  in  2  token kind: 00 operand, 01 add, 10 mul, 11 end.
- `tok_data`  in  N  operand value; ignored for other kinds.
- `alu_opcode`  out  3  ALU opcode: 0xx nop, 100 add, 101 mul, 110 push, 111 pop.
- `alu_in`  out  N  ALU operand.
- `alu_out`  in  N  ALU result; valid the cycle after a pop is issued.
- `alu_overflow`  in  1  ALU overflow flag; valid the cycle after an add/mul is issued.
- `res_valid`  out  1  one-cycle result pulse.
- `res_data`  out  N  expression result, signed two's complement.
- `res_overflow`  out  1  an overflow occurred during the expression.
- `res_error`  out  1  the expression was malformed or aborted.

## Operation
- Handshake: a token transfers when `tok_valid && tok_ready`. `tok_ready` is high only in ACCEPT and FLUSH.
- All ALU-side outputs are registered. `alu_opcode` is 000 in every state except ISSUE and DRAIN.
- States: ACCEPT, ISSUE, CHECK, CAPTURE, DRAIN, FLUSH.
- ACCEPT, on transfer:
  - Operand with `depth < DEPTH`: latch push 110 with `alu_in = tok_data`, go to ISSUE, `depth++`.
  - Add/mul with `depth >= 2`: latch 100/101, go to ISSUE, `depth--`.
  - End with `depth == 1`: latch pop 111, go to ISSUE, `depth = 0`.
  - Any other case is an error, handled as described below.
- ISSUE: the opcode is held for exactly one cycle. Next state:
  - CHECK after add/mul.
  - CAPTURE after pop.
  - ACCEPT after push.
- CHECK: OR `alu_overflow` into a sticky `ovf` flag, then go to ACCEPT.
- CAPTURE: `res_data <= alu_out`, `res_overflow <= ovf`, `res_error <= 0`, pulse `res_valid`, clear `ovf`, go to ACCEPT.
- Error handling:
  - On error, pulse `res_valid` with `res_error = 1`, `res_overflow = ovf` and `res_data = 0`, then clear `ovf`.
  - If `depth > 0`, go to DRAIN: issue 111 for one cycle per entry, then a 000 cycle between pops, `depth--` each time.
  - Then go to FLUSH. FLUSH is skipped if the offending token was end.
  - FLUSH discards tokens until an end token is consumed, then returns to ACCEPT.
- Reset values: `tok_ready` 0 while `rst` is high and 1 from the first cycle after; `alu_opcode` 000; `alu_in` 0; `res_valid`, `res_data`, `res_overflow`, `res_error` all 0; `depth` 0; state ACCEPT.
- Reset mid-operation: the ALU is reset by the same `rst`. No drain is performed and all in-flight tokens are lost.

## Timing
- Operand: 2 cycles from transfer to next `tok_ready`.
- Add/mul: 3 cycles.
- End: 3 cycles. `res_valid` is asserted 2 cycles after the end token transfers.
- Error: `res_valid` is asserted the cycle after the offending transfer. DRAIN takes 2 cycles per remaining entry.
- Results are held until the next `res_valid` pulse. There is no backpressure on the result port.

## Configuration
- `SEQ_OVF_ABORT_EN` defined:
  - An overflow seen in CHECK is treated as an error.
  - Error pulse carries `res_error = 1` and `res_overflow = 1`.
  - The block then drains the remaining `depth` entries and flushes to end.
- `SEQ_OVF_ABORT_EN` undefined:
  - Overflow is only sticky and is reported with the final result.
  - The expression runs to completion.

## Test plan
- Tokens 3, 5, add, end → `alu_opcode` sequence 110, 110, 100, 111 → `res_data` 8, `res_overflow` 0, `res_error` 0.
- Tokens 7, 1, add, end (N=4) → `res_data` 4'b1000, `res_overflow` 1. With `SEQ_OVF_ABORT_EN`: error pulse instead, followed by 1 drain pop.
- Tokens 2, add → error pulse; 1 drain pop; then tokens 5, end are flushed. A following 4, end → `res_data` 4.
- Nine operands (DEPTH=8) → error on the 9th; 8 drain pops, each separated by a nop.
- Tokens 1, 2, end → error, 2 drain pops, no flush. The next expression 6, 3, mul, end → `res_data` 18 truncated to 4'b0010, `res_overflow` 1.
- Randomly toggle `tok_valid` mid-expression, then assert `rst` after 2 pushes → all outputs return to reset values. A following 1, 1, add, end → `res_data` 2.
